// File: rtl/sec_pkg.sv
// Shared constants, state type and width helper for the AN-code single-error location search.
package sec_pkg;

  function automatic int loc_width(input int n);
    return $clog2(n + 1) + 1;
  endfunction

  localparam int SEC_A  = 1939;
  localparam int SEC_N  = 19;
  localparam int SEC_RW = $clog2(SEC_A);
  localparam int SEC_LW = loc_width(SEC_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sec_state_t;

endpackage

// File: rtl/sec_pow2_mod_step.sv
// One modular doubling step: p2 = (2*p) mod A, valid for p < A.
module sec_pow2_mod_step
  import sec_pkg::*;
#(
  parameter int A  = SEC_A,
  parameter int RW = $clog2(A)
) (
  input  logic [RW-1:0] p,
  output logic [RW-1:0] p2
);

  localparam logic [RW:0] A_W = A[RW:0];

  logic [RW:0] dbl;

  // The subtraction is done at RW bits: when 2p >= A the true result is below A < 2^RW.
  always_comb begin
    dbl = {p, 1'b0};
    p2  = (dbl >= A_W) ? (dbl[RW-1:0] - A_W[RW-1:0]) : dbl[RW-1:0];
  end

endmodule

// File: rtl/sec_lsearch.sv
// Sequential search for the single-error location of an AN-coded word from its residue mod A.
// Optional codeword correction output is enabled by defining SEC_LSEARCH_CORRECT_EN.
//
// state  | meaning
// IDLE   | waiting for start; results from the last search held
// SEARCH | testing +/-2^k mod A against r, one k per cycle
// DONE   | done pulse; results valid
module sec_lsearch
  import sec_pkg::*;
#(
  parameter int A  = SEC_A,
  parameter int N  = SEC_N,
  parameter int RW = $clog2(A),
  parameter int LW = loc_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] r_in,
`ifdef SEC_LSEARCH_CORRECT_EN
  input  logic [N-1:0]  cw_in,
  output logic [N-1:0]  cw_out,
`endif
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] l_out,
  output logic          found,
  output logic          zero,
  output logic          uncorrectable
);

  localparam int            KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [RW-1:0] A_R    = A[RW-1:0];

  sec_state_t    state, state_nxt;
  logic [RW-1:0] r, p, p_dbl;
  logic [KW-1:0] k;
  logic          hit_pos, hit_neg, k_last;
  logic [LW-1:0] l_mag;

  sec_pow2_mod_step #(.A(A), .RW(RW)) u_step (
    .p  (p),
    .p2 (p_dbl)
  );

  always_comb begin
    hit_pos = (r == p);
    hit_neg = (r == (A_R - p));
    k_last  = (k == K_LAST);
    l_mag   = LW'(k) + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (r_in == '0) ? DONE : SEARCH;
      end
      SEARCH: begin
        busy = 1'b1;
        if (hit_pos || hit_neg || k_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEC_LSEARCH_CORRECT_EN
  logic [N-1:0] bit_k;

  always_comb begin
    bit_k    = '0;
    bit_k[k] = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r             <= '0;
      p             <= RW'(1);
      k             <= '0;
      l_out         <= '0;
      found         <= 1'b0;
      zero          <= 1'b0;
      uncorrectable <= 1'b0;
`ifdef SEC_LSEARCH_CORRECT_EN
      cw_out        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r             <= r_in;
            p             <= RW'(1);
            k             <= '0;
            l_out         <= '0;
            found         <= 1'b0;
            uncorrectable <= 1'b0;
            zero          <= (r_in == '0);
`ifdef SEC_LSEARCH_CORRECT_EN
            // Zero and uncorrectable outcomes pass the word through untouched.
            cw_out        <= cw_in;
`endif
          end
        end
        SEARCH: begin
          if (hit_pos) begin
            l_out  <= l_mag;
            found  <= 1'b1;
`ifdef SEC_LSEARCH_CORRECT_EN
            cw_out <= cw_out - bit_k;
`endif
          end else if (hit_neg) begin
            l_out  <= -l_mag;
            found  <= 1'b1;
`ifdef SEC_LSEARCH_CORRECT_EN
            cw_out <= cw_out + bit_k;
`endif
          end else if (k_last) begin
            l_out         <= '0;
            uncorrectable <= 1'b1;
          end else begin
            p <= p_dbl;
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_lsearch.sv
// Randomised and directed bench for sec_lsearch against a plain-arithmetic location model.
module tb_sec_lsearch;
  import sec_pkg::*;

  localparam int A  = 1939;
  localparam int N  = 19;
  localparam int RW = 11;
  localparam int LW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [RW-1:0]        r_in;
  logic                 busy, done, found, zero, uncorrectable;
  logic signed [LW-1:0] l_out;
`ifdef SEC_LSEARCH_CORRECT_EN
  logic [N-1:0]         cw_in, cw_out;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sec_lsearch dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .r_in          (r_in),
`ifdef SEC_LSEARCH_CORRECT_EN
    .cw_in         (cw_in),
    .cw_out        (cw_out),
`endif
    .busy          (busy),
    .done          (done),
    .l_out         (l_out),
    .found         (found),
    .zero          (zero),
    .uncorrectable (uncorrectable)
  );

  // Location and latency straight from the code definition: walk 2^(j-1) mod A for j=1..N.
  function automatic void ref_search(input int r, output int l, output int lat);
    int pw;
    l   = 0;
    lat = N + 1;
    if (r == 0) begin
      lat = 1;
      return;
    end
    pw = 1;
    for (int j = 1; j <= N; j++) begin
      if (r == pw) begin l = j;  lat = j + 1; return; end
      if (r == A - pw) begin l = -j; lat = j + 1; return; end
      pw = (pw * 2) % A;
    end
  endfunction

  function automatic int ref_cw(input int cw, input int l);
    int mask;
    mask = (1 << N) - 1;
    if (l > 0) return (cw - (1 << (l - 1))) & mask;
    if (l < 0) return (cw + (1 << (-l - 1))) & mask;
    return cw;
  endfunction

  function automatic int pow2_mod(input int e);
    int v;
    v = 1;
    for (int i = 0; i < e; i++) v = (v * 2) % A;
    return v;
  endfunction

  // Issues a start and returns sampled in the done cycle (or when the cycle budget expires).
  task automatic run_search(input int r, input int cw, output int lat);
    @(negedge clk);
    start = 1'b1;
    r_in  = RW'(r);
`ifdef SEC_LSEARCH_CORRECT_EN
    cw_in = N'(cw);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat <= N + 4) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    r_in  = '0;
`ifdef SEC_LSEARCH_CORRECT_EN
    cw_in = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, found, zero, uncorrectable} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got busy/done/found/zero/unc=%b want 00000",
               {busy, done, found, zero, uncorrectable});
    end
    tests++;
    if (l_out !== '0) begin
      fails++;
      $display("FAIL reset_l_out got %0d want 0", l_out);
    end
`ifdef SEC_LSEARCH_CORRECT_EN
    tests++;
    if (cw_out !== '0) begin
      fails++;
      $display("FAIL reset_cw_out got %0d want 0", cw_out);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    int vec [6] = '{109, 1830, 1, 195, 0, 5};
    int el, elat, lat;
    foreach (vec[i]) begin
      ref_search(vec[i], el, elat);
      run_search(vec[i], 0, lat);
      tests++;
      if (lat != elat) begin
        fails++;
        $display("FAIL dir_latency r=%0d got %0d want %0d", vec[i], lat, elat);
      end
      tests++;
      if (int'(l_out) != el) begin
        fails++;
        $display("FAIL dir_l_out r=%0d got %0d want %0d", vec[i], l_out, el);
      end
      tests++;
      if ({found, zero, uncorrectable} !== {el != 0, vec[i] == 0, vec[i] != 0 && el == 0}) begin
        fails++;
        $display("FAIL dir_flags r=%0d got f/z/u=%b%b%b want %b%b%b", vec[i], found, zero,
                 uncorrectable, el != 0, vec[i] == 0, vec[i] != 0 && el == 0);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || int'(l_out) != el) begin
        fails++;
        $display("FAIL dir_pulse_hold r=%0d got done=%b l_out=%0d want 0 %0d", vec[i], done, l_out, el);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start = 1'b1;
    r_in  = RW'(379);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1;
    r_in  = RW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (done !== 1'b1 && lat <= N + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat != 20) begin
      fails++;
      $display("FAIL busy_latency got %0d want 20", lat);
    end
    tests++;
    if (int'(l_out) != 19 || found !== 1'b1) begin
      fails++;
      $display("FAIL busy_ignore got l_out=%0d found=%b want 19 1", l_out, found);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat, ndone;
    @(negedge clk);
    start = 1'b1;
    r_in  = RW'(1744);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, found, zero, uncorrectable} !== 5'b0 || l_out !== '0) begin
      fails++;
      $display("FAIL abort_state got busy/done/f/z/u=%b l_out=%0d want 00000 0",
               {busy, done, found, zero, uncorrectable}, l_out);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL abort_no_done got %0d busy/done cycles want 0", ndone);
    end
    run_search(1744, 0, lat);
    tests++;
    if (int'(l_out) != 16 || lat != 17) begin
      fails++;
      $display("FAIL abort_restart got l_out=%0d lat=%0d want 16 17", l_out, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int r, cw, el, elat, lat, mode, j;
    for (int it = 0; it < 80; it++) begin
      mode = int'($urandom_range(0, 4));
      if (mode <= 1) r = int'($urandom_range(0, (1 << RW) - 1));
      else if (mode == 4) r = 0;
      else begin
        j = int'($urandom_range(1, N));
        r = (mode == 2) ? pow2_mod(j - 1) : A - pow2_mod(j - 1);
      end
      cw = int'($urandom_range(0, (1 << N) - 1));
      ref_search(r, el, elat);
      run_search(r, cw, lat);
      tests++;
      if (lat != elat || int'(l_out) != el) begin
        fails++;
        $display("FAIL rand_result r=%0d got l=%0d lat=%0d want l=%0d lat=%0d", r, l_out, lat, el, elat);
      end
      tests++;
      if ({found, zero, uncorrectable} !== {el != 0, r == 0, r != 0 && el == 0}) begin
        fails++;
        $display("FAIL rand_flags r=%0d got f/z/u=%b%b%b want %b%b%b", r, found, zero,
                 uncorrectable, el != 0, r == 0, r != 0 && el == 0);
      end
`ifdef SEC_LSEARCH_CORRECT_EN
      tests++;
      if (int'(cw_out) != ref_cw(cw, el)) begin
        fails++;
        $display("FAIL rand_cw r=%0d got %0d want %0d", r, cw_out, ref_cw(cw, el));
      end
`endif
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL rand_pulse r=%0d got done=%b want 0", r, done);
      end
    end
  endtask

  task automatic test_sweep();
    int r, cw, lat, want;
    for (int j = 1; j <= N; j++) begin
      for (int s = 0; s < 2; s++) begin
        r    = (s == 0) ? pow2_mod(j - 1) : A - pow2_mod(j - 1);
        want = (s == 0) ? j : -j;
        cw   = int'($urandom_range(0, (1 << N) - 1));
        run_search(r, cw, lat);
        tests++;
        if (int'(l_out) != want || lat != j + 1 || found !== 1'b1) begin
          fails++;
          $display("FAIL sweep r=%0d got l=%0d lat=%0d found=%b want l=%0d lat=%0d found=1",
                   r, l_out, lat, found, want, j + 1);
        end
`ifdef SEC_LSEARCH_CORRECT_EN
        tests++;
        if (int'(cw_out) != ref_cw(cw, want)) begin
          fails++;
          $display("FAIL sweep_cw r=%0d got %0d want %0d", r, cw_out, ref_cw(cw, want));
        end
`endif
        @(posedge clk); #1;
      end
    end
  endtask

`ifdef SEC_LSEARCH_CORRECT_EN
  task automatic test_correct();
    int lat;
    run_search(109, 7 * 1939 + 2048, lat);
    tests++;
    if (int'(cw_out) != 13573 || int'(l_out) != 12) begin
      fails++;
      $display("FAIL correct_cw got cw_out=%0d l_out=%0d want 13573 12", cw_out, l_out);
    end
    run_search(0, 12345, lat);
    tests++;
    if (int'(cw_out) != 12345) begin
      fails++;
      $display("FAIL correct_zero_pass got %0d want 12345", cw_out);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
`ifdef SEC_LSEARCH_CORRECT_EN
    test_correct();
`endif
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
